div_sign_restore: RTL

//  Back end of the signed divider: re-applies signs to the unsigned quotient/remainder magnitudes.

---
 rtl/div_sign_restore.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/div_sign_restore.sv
`default_nettype none
// ============================================================================
// Module      : div_sign_restore
// Description : Signed-divider back end. Re-applies the quotient sign (signo)
//               and dividend sign (sign_n) to the unsigned magnitudes from the
//               divide core. The results pass through a registered
//               valid/ready stage with a one-entry skid buffer. The stage also
//               provides a quotient overflow flag and a saturating counter of
//               overflowed results.
//               Optional macro DIV_SIGN_SAT_EN: when defined, an overflowed
//               quotient clamps to the nearest representable value instead of
//               wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module div_sign_restore #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     q_mag,
    input  logic [W-1:0]     r_mag,
    input  logic             signo,
    input  logic             sign_n,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     q_out,
    output logic [W-1:0]     r_out,
    output logic             ovf,
    output logic [CNT_W-1:0] ovf_cnt
);

    localparam logic [W-1:0]     c_one     = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]     c_max_pos = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]     c_min_neg = {1'b1, {(W-1){1'b0}}};
    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    // Sign-applied versions of the incoming magnitudes
    logic [W-1:0] w_q_conv;
    logic [W-1:0] w_r_conv;
    logic         w_ovf_in;

    // State: output register, skid entry, overflow counter
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     q_out_q,     q_out_d;
    logic [W-1:0]     r_out_q,     r_out_d;
    logic             ovf_q,       ovf_d;
    logic             skid_full_q, skid_full_d;
    logic [W-1:0]     skid_q_q,    skid_q_d;
    logic [W-1:0]     skid_r_q,    skid_r_d;
    logic             skid_ovf_q,  skid_ovf_d;
    logic [CNT_W-1:0] ovf_cnt_q,   ovf_cnt_d;

    logic w_accept;
    logic w_out_load;

    // Sign application and overflow detection for the incoming result
    always_comb begin
        // Only -2^(W-1) has a magnitude with the MSB set that is still representable
        if (signo) begin
            w_ovf_in = q_mag[W-1] & (|q_mag[W-2:0]);
        end else begin
            w_ovf_in = q_mag[W-1];
        end

        w_q_conv = signo ? (~q_mag + c_one) : q_mag;
`ifdef DIV_SIGN_SAT_EN
        if (w_ovf_in) begin
            w_q_conv = signo ? c_min_neg : c_max_pos;
        end
`endif
        // Negating a zero magnitude yields zero, so no special case is needed
        w_r_conv = sign_n ? (~r_mag + c_one) : r_mag;
    end

    assign in_ready   = ~skid_full_q;
    assign w_accept   = in_valid & ~skid_full_q;
    assign w_out_load = ~out_valid_q | out_ready;

    // Next-state for the output register, skid entry and overflow counter
    always_comb begin
        out_valid_d = out_valid_q;
        q_out_d     = q_out_q;
        r_out_d     = r_out_q;
        ovf_d       = ovf_q;
        skid_full_d = skid_full_q;
        skid_q_d    = skid_q_q;
        skid_r_d    = skid_r_q;
        skid_ovf_d  = skid_ovf_q;
        ovf_cnt_d   = ovf_cnt_q;

        if (w_out_load) begin
            if (skid_full_q) begin
                // in_ready is low while the skid is full, so no input competes here
                out_valid_d = 1'b1;
                q_out_d     = skid_q_q;
                r_out_d     = skid_r_q;
                ovf_d       = skid_ovf_q;
                skid_full_d = 1'b0;
            end else if (w_accept) begin
                out_valid_d = 1'b1;
                q_out_d     = w_q_conv;
                r_out_d     = w_r_conv;
                ovf_d       = w_ovf_in;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (w_accept) begin
            // Output is stalled: park the new result in the skid entry
            skid_full_d = 1'b1;
            skid_q_d    = w_q_conv;
            skid_r_d    = w_r_conv;
            skid_ovf_d  = w_ovf_in;
        end

        if (out_valid_q && out_ready && ovf_q && !(&ovf_cnt_q)) begin
            ovf_cnt_d = ovf_cnt_q + c_cnt_one;
        end
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            q_out_q     <= '0;
            r_out_q     <= '0;
            ovf_q       <= 1'b0;
            skid_full_q <= 1'b0;
            skid_q_q    <= '0;
            skid_r_q    <= '0;
            skid_ovf_q  <= 1'b0;
            ovf_cnt_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            q_out_q     <= q_out_d;
            r_out_q     <= r_out_d;
            ovf_q       <= ovf_d;
            skid_full_q <= skid_full_d;
            skid_q_q    <= skid_q_d;
            skid_r_q    <= skid_r_d;
            skid_ovf_q  <= skid_ovf_d;
            ovf_cnt_q   <= ovf_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign q_out     = q_out_q;
    assign r_out     = r_out_q;
    assign ovf       = ovf_q;
    assign ovf_cnt   = ovf_cnt_q;

endmodule
`default_nettype wire
